// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared VGA 640x480@60 timing constants and helpers
package pong_pkg;

    localparam int H_ACTIVE_DEF = 640;
    localparam int H_FP_DEF     = 16;
    localparam int H_SYNC_DEF   = 96;
    localparam int H_BP_DEF     = 48;
    localparam int V_ACTIVE_DEF = 480;
    localparam int V_FP_DEF     = 10;
    localparam int V_SYNC_DEF   = 2;
    localparam int V_BP_DEF     = 33;

    localparam int H_TOTAL_DEF      = H_ACTIVE_DEF + H_FP_DEF + H_SYNC_DEF + H_BP_DEF;
    localparam int V_TOTAL_DEF      = V_ACTIVE_DEF + V_FP_DEF + V_SYNC_DEF + V_BP_DEF;
    localparam int H_SYNC_START_DEF = H_ACTIVE_DEF + H_FP_DEF;
    localparam int H_SYNC_END_DEF   = H_SYNC_START_DEF + H_SYNC_DEF;
    localparam int V_SYNC_START_DEF = V_ACTIVE_DEF + V_FP_DEF;
    localparam int V_SYNC_END_DEF   = V_SYNC_START_DEF + V_SYNC_DEF;

    typedef struct packed {
        logic hsync;
        logic vsync;
        logic active;
    } raw_timing_t;

    function automatic logic in_window(input int pos, input int start, input int len);
        return (pos >= start) && (pos < start + len);
    endfunction

endpackage

// File: rtl/delay_line.sv
// rtl/delay_line.sv - fixed-depth shift register with synchronous clear
module delay_line #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] tap,
    output logic [WIDTH-1:0] dout
);

    logic [WIDTH-1:0] stage [DEPTH];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) stage[i] <= '0;
        end else begin
            stage[0] <= din;
            for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
        end
    end

    assign dout = stage[DEPTH-1];

    // tap is the value one stage short of dout, used to qualify a register that sits beside the last stage
    if (DEPTH == 1) begin : g_tap_in
        assign tap = din;
    end else begin : g_tap_stage
        assign tap = stage[DEPTH-2];
    end

endmodule

// File: rtl/vga_timing_out.sv
// rtl/vga_timing_out.sv - VGA raster counters, sync generation and aligned colour output
module vga_timing_out
    import pong_pkg::*;
#(
    parameter int   H_ACTIVE = H_ACTIVE_DEF,
    parameter int   H_FP     = H_FP_DEF,
    parameter int   H_SYNC   = H_SYNC_DEF,
    parameter int   H_BP     = H_BP_DEF,
    parameter int   V_ACTIVE = V_ACTIVE_DEF,
    parameter int   V_FP     = V_FP_DEF,
    parameter int   V_SYNC   = V_SYNC_DEF,
    parameter int   V_BP     = V_BP_DEF,
    parameter logic SYNC_POL = 1'b0,
    parameter int   PIX_LAT  = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic [7:0] pix_red,
    input  logic [7:0] pix_green,
    input  logic [7:0] pix_blue,
    output logic [9:0] hcount,
    output logic [9:0] vcount,
    output logic       active,
    output logic       frame_start,
    output logic [7:0] RED,
    output logic [7:0] GREEN,
    output logic [7:0] BLUE,
    output logic       HSync,
    output logic       VSync
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
    localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

    if (H_TOTAL > 1023 || V_TOTAL > 1023) begin : g_bad_totals
        $error("vga_timing_out: line or frame total exceeds 10-bit counter range");
    end
    if (PIX_LAT < 0 || PIX_LAT > 3) begin : g_bad_lat
        $error("vga_timing_out: PIX_LAT must be 0..3");
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            hcount <= '0;
            vcount <= '0;
        end else if (enable) begin
            if (hcount == H_LAST) begin
                hcount <= '0;
                vcount <= (vcount == V_LAST) ? '0 : vcount + 10'd1;
            end else begin
                hcount <= hcount + 10'd1;
            end
        end
    end

    assign active      = (hcount < 10'(H_ACTIVE)) && (vcount < 10'(V_ACTIVE));
    assign frame_start = enable && !rst && (hcount == '0) && (vcount == '0);

    raw_timing_t raw, raw_tap, raw_pin;
    logic        tap_unused;

    // A paused raster feeds blanking into the pipeline so the pins go quiet
    always_comb begin
        raw        = '0;
        raw.hsync  = enable && in_window(int'(hcount), H_ACTIVE + H_FP, H_SYNC);
        raw.vsync  = enable && in_window(int'(vcount), V_ACTIVE + V_FP, V_SYNC);
        raw.active = enable && active;
    end

    delay_line #(
        .WIDTH($bits(raw_timing_t)),
        .DEPTH(PIX_LAT + 1)
    ) u_sync_dly (
        .clk  (clk),
        .rst  (rst),
        .din  (raw),
        .tap  (raw_tap),
        .dout (raw_pin)
    );

    assign tap_unused = raw_tap.hsync ^ raw_tap.vsync;

    always_ff @(posedge clk) begin
        if (rst) begin
            RED   <= '0;
            GREEN <= '0;
            BLUE  <= '0;
        end else if (raw_tap.active) begin
            RED   <= pix_red;
            GREEN <= pix_green;
            BLUE  <= pix_blue;
        end else begin
            RED   <= '0;
            GREEN <= '0;
            BLUE  <= '0;
        end
    end

    assign HSync = raw_pin.hsync ? SYNC_POL : ~SYNC_POL;
    assign VSync = raw_pin.vsync ? SYNC_POL : ~SYNC_POL;

endmodule

// File: tb/tb_vga_timing_out.sv
// tb/tb_vga_timing_out.sv - raster/sync/colour bench with a cycle model of the VGA timing
module tb_vga_timing_out;

    // Full horizontal timing; vertical shortened so a whole frame fits in a short run
    localparam int HA = 640, HF = 16, HS = 96, HB = 48;
    localparam int VA = 24, VF = 4, VS = 2, VB = 3;
    localparam int HT = HA + HF + HS + HB;
    localparam int VT = VA + VF + VS + VB;
    localparam int FRAME = HT * VT;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       enable = 1'b1;
    logic [7:0] pix_red = '0, pix_green = '0, pix_blue = '0;
    logic [9:0] hcount, vcount;
    logic       active, frame_start, HSync, VSync;
    logic [7:0] RED, GREEN, BLUE;

    vga_timing_out #(
        .H_ACTIVE(HA), .H_FP(HF), .H_SYNC(HS), .H_BP(HB),
        .V_ACTIVE(VA), .V_FP(VF), .V_SYNC(VS), .V_BP(VB),
        .SYNC_POL(1'b0), .PIX_LAT(1)
    ) dut (
        .clk(clk), .rst(rst), .enable(enable),
        .pix_red(pix_red), .pix_green(pix_green), .pix_blue(pix_blue),
        .hcount(hcount), .vcount(vcount), .active(active), .frame_start(frame_start),
        .RED(RED), .GREEN(GREEN), .BLUE(BLUE), .HSync(HSync), .VSync(VSync)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit rst;
        bit en;
        int h;
        int v;
        int pr;
        int pg;
        int pb;
    } cyc_t;

    cyc_t cur, q1, q2;
    int   t = 0;
    bit   checking = 1'b0;
    int   n_cmp = 0, n_bad = 0;
    int   next_pr = 0, next_pg = 0, next_pb = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d at t=%0d", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_to(input int target);
        int n;
        n = 0;
        while (t != target && n < 2 * FRAME) begin
            tick();
            n++;
        end
        if (t != target) begin
            n_cmp++;
            n_bad++;
            $display("FAIL run_to_timeout: got t=%0d expected %0d", t, target);
        end
    endtask

    // Model: raster position is the enabled-clock count since reset; pins see coordinates two cycles late
    always @(negedge clk) begin
        if (checking) begin
            int  h, v;
            bit  ok, vis;
            h = t % HT;
            v = t / HT;
            cur = '{rst, enable, h, v, int'(pix_red), int'(pix_green), int'(pix_blue)};
            chk("hcount", hcount, h);
            chk("vcount", vcount, v);
            chk("active", active, (h < HA && v < VA) ? 1 : 0);
            chk("frame_start", frame_start, (enable && !rst && t == 0) ? 1 : 0);
            ok  = !q1.rst && !q2.rst && q2.en;
            vis = ok && q2.h < HA && q2.v < VA;
            chk("HSync", HSync, (ok && q2.h >= HA + HF && q2.h < HA + HF + HS) ? 0 : 1);
            chk("VSync", VSync, (ok && q2.v >= VA + VF && q2.v < VA + VF + VS) ? 0 : 1);
            chk("RED",   RED,   vis ? q1.pr : 0);
            chk("GREEN", GREEN, vis ? q1.pg : 0);
            chk("BLUE",  BLUE,  vis ? q1.pb : 0);
            q2 = q1;
            q1 = cur;
            next_pr = h & 255;
            next_pg = v & 255;
            next_pb = (h ^ 'h5A) & 255;
            t = rst ? 0 : (enable ? (t + 1) % FRAME : t);
        end
    end

    // Game-logic stand-in: colour for the coordinate issued one clock earlier
    initial begin
        forever begin
            @(posedge clk);
            #1;
            pix_red   = 8'(next_pr);
            pix_green = 8'(next_pg);
            pix_blue  = 8'(next_pb);
        end
    end

    initial begin
        int lows, first, n, vl;
        q1 = '{1'b1, 1'b0, 0, 0, 0, 0, 0};
        q2 = q1;
        rst = 1'b1;
        enable = 1'b1;
        tick();
        checking = 1'b1;
        repeat (4) tick();
        @(negedge clk);
        chk("rst_hcount", hcount, 0);
        chk("rst_frame_start", frame_start, 0);
        chk("rst_HSync", HSync, 1);
        chk("rst_VSync", VSync, 1);
        chk("rst_RED", RED, 0);

        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("first_frame_start", frame_start, 1);
        chk("first_hcount", hcount, 0);
        chk("first_vcount", vcount, 0);

        run_to(10);
        @(negedge clk);
        chk("red_at_t10", RED, 8);
        chk("hsync_idle_t10", HSync, 1);

        run_to(HT + 300);
        enable = 1'b0;
        @(negedge clk);
        chk("red_before_pause", RED, 42);
        repeat (9) tick();
        @(negedge clk);
        chk("pause_hcount", hcount, 300);
        chk("pause_vcount", vcount, 1);
        chk("pause_RED", RED, 0);
        chk("pause_HSync", HSync, 1);
        tick();
        enable = 1'b1;
        tick();
        @(negedge clk);
        chk("resume_hcount", hcount, 301);

        run_to(2 * HT);
        lows = 0;
        first = -1;
        repeat (HT) begin
            @(negedge clk);
            if (HSync === 1'b0) begin
                lows++;
                if (first < 0) first = int'(hcount);
            end
            tick();
        end
        chk("hsync_low_clocks", lows, 96);
        chk("hsync_fall_hcount", first, 658);

        n = 0;
        @(negedge clk);
        while (frame_start !== 1'b1 && n < FRAME + 100) begin
            tick();
            @(negedge clk);
            n++;
        end
        chk("frame_start_seen", frame_start, 1);
        n = 0;
        vl = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
            if (VSync === 1'b0) vl++;
        end while (frame_start !== 1'b1 && n < FRAME + 100);
        chk("frame_period", n, 26400);
        chk("vsync_low_clocks", vl, 1600);

        run_to(12 * HT + 37);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        @(negedge clk);
        chk("mid_rst_hcount", hcount, 0);
        chk("mid_rst_vcount", vcount, 0);
        chk("mid_rst_frame_start", frame_start, 1);
        chk("mid_rst_HSync", HSync, 1);
        chk("mid_rst_VSync", VSync, 1);
        chk("mid_rst_RED", RED, 0);
        repeat (300) tick();
        @(negedge clk);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/vga_timing_out.md
VGA_TIMING_OUT -- requirements
Module: vga_timing_out

Interface
REQ-001 Parameter H_ACTIVE, 640, visible pixels per line.
REQ-002 Parameters H_FP/H_SYNC/H_BP, 16/96/48, horizontal front porch, sync and back porch in clocks; line total 800.
REQ-003 Parameter V_ACTIVE, 480, visible lines per frame.
REQ-004 Parameters V_FP/V_SYNC/V_BP, 10/2/33, vertical porches and sync in lines; frame total 525.
REQ-005 Parameter SYNC_POL, 0, asserted level of HSync/VSync (0 = active-low).
REQ-006 Parameter PIX_LAT, 1, clocks from coordinate output to matching colour input; legal range 0..3.
REQ-007 clk  in  1  pixel clock (25.175 MHz nominal); the block's only clock.
REQ-008 rst  in  1  synchronous, active-high reset.
REQ-009 enable  in  1  advance timing when high.
REQ-010 pix_red/pix_green/pix_blue  in  8 each  colour from game logic for the coordinate issued PIX_LAT clocks earlier.
REQ-011 hcount  out  10  current horizontal position, 0..799.
REQ-012 vcount  out  10  current line, 0..524.
REQ-013 active  out  1  high when hcount<H_ACTIVE and vcount<V_ACTIVE.
REQ-014 frame_start  out  1  one-clock pulse when hcount=0 and vcount=0 while enabled.
REQ-015 RED/GREEN/BLUE  out  8 each  registered VGA colour.
REQ-016 HSync/VSync  out  1 each  registered VGA syncs.

Function
REQ-017 hcount increments by 1 per enabled clock; at 799 it wraps to 0 and vcount increments.
REQ-018 vcount wraps 524->0 in the same clock hcount wraps 799->0.
REQ-019 With enable low, hcount/vcount hold, frame_start is 0, and counting resumes from the held value on the first enabled clock.
REQ-020 Raw hsync is asserted for H_ACTIVE+H_FP <= hcount < H_ACTIVE+H_FP+H_SYNC (656..751).
REQ-021 Raw vsync is asserted for V_ACTIVE+V_FP <= vcount < V_ACTIVE+V_FP+V_SYNC (490..491).
REQ-022 Raw hsync, vsync and active are delayed PIX_LAT+1 clocks through a shift pipeline so HSync/VSync/RGB at the pins refer to the same coordinate.
REQ-023 RGB outputs register pix_* when the delayed active is high, else 0x00.
REQ-024 Total latency: coordinate at clock N -> RGB/HSync/VSync at pins after clock N+PIX_LAT+1.
REQ-025 While enable is low the pipeline keeps shifting with inactive inputs: syncs go inactive (!SYNC_POL) and RGB goes 0 after PIX_LAT+1 clocks.
REQ-026 Sync levels at pins equal SYNC_POL when asserted, !SYNC_POL otherwise.
REQ-027 Parameter sums that exceed 1023 are illegal; elaboration fails via assertion.

Reset
REQ-028 While rst is high at a clock edge: hcount=0, vcount=0, frame_start=0, all pipeline stages cleared, RGB=0, HSync=VSync=!SYNC_POL.
REQ-029 Reset mid-frame aborts the frame; first enabled clock after rst deasserts produces frame_start=1 with hcount=0,vcount=0.
REQ-030 rst has priority over enable.

Structure
REQ-031 Default timing constants, and derived H_TOTAL/V_TOTAL/sync start/end values, live in shared package pong_pkg.
REQ-032 The PIX_LAT+1 delay is one sub-module, delay_line (parameterised width and depth, synchronous reset), instantiated once for {hsync, vsync, active}.

Verification
REQ-033 Reset 5 clocks, enable high -> first clock frame_start=1, hcount=0, vcount=0; HSync/VSync high (SYNC_POL=0) until first sync region.
REQ-034 Run one line -> raw hsync low for exactly 96 clocks starting hcount=656; pin HSync falls 2 clocks later (PIX_LAT=1).
REQ-035 Run one full frame -> frame_start period = 420000 clocks; VSync low for exactly 1600 clocks.
REQ-036 Drive pix_red=hcount[7:0] delayed 1 clock -> RED at pins equals issued hcount[7:0] for active pixels, 0 at hcount 640..799 and lines 480..524.
REQ-037 Drop enable at hcount=300 for 10 clocks -> counters hold at 300, RGB=0 and syncs inactive after 2 clocks, resume at 301 on re-enable.
REQ-038 Assert rst at vcount=200 -> next clock all outputs at reset values; frame restarts at 0,0.
